// File: rtl/danger_scheduler.sv
// -----------------------------------------------------------------------------
// danger_scheduler
//
// Owns three obstacle slots for the danger renderer. On every frame tick while
// the game runs, each active slot scrolls left by `speed` pixels and is retired
// once it would reach or pass x = 0. New obstacles are spawned into the
// lowest-indexed free slot after a pseudo-random gap of frame ticks. The type
// and the next gap are both drawn from one free-running 16-bit LFSR sample.
//
// Ports
//   clk                  system clock
//   rst                  asynchronous, active-high reset
//   frame_tick           one-cycle pulse per frame (vertical blanking)
//   run                  1 = game running, 0 = freeze slots and gap (LFSR runs)
//   restart              one-cycle pulse: clear slots, reload gap, reseed LFSR
//   speed[3:0]           pixels moved per frame tick
//   new_danger_pos1..3   right-edge x of each slot (registered)
//   danger_type1..3      obstacle type of each slot (registered)
//   danger_en1..3        slot active flags (registered)
//   spawn_pulse          high for the one cycle following a spawn
// -----------------------------------------------------------------------------
module danger_scheduler #(
    parameter int unsigned SPAWN_X   = 700,
    parameter int unsigned MIN_GAP   = 40,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       restart,
    input  logic [3:0] speed,
    output logic [9:0] new_danger_pos1,
    output logic [9:0] new_danger_pos2,
    output logic [9:0] new_danger_pos3,
    output logic [2:0] danger_type1,
    output logic [2:0] danger_type2,
    output logic [2:0] danger_type3,
    output logic       danger_en1,
    output logic       danger_en2,
    output logic       danger_en3,
    output logic       spawn_pulse
);

    localparam logic [9:0] SPAWN_POS = 10'(SPAWN_X);
    localparam logic [7:0] GAP_MIN   = 8'(MIN_GAP);

    // State registers
    logic [15:0] r_lfsr;
    logic [9:0]  r_pos  [3];
    logic [2:0]  r_type [3];
    logic [2:0]  r_en;
    logic [7:0]  r_gap;
    logic        r_spawn_pulse;

    // Next-state and helper wires
    logic        w_fb;
    logic        w_tick;
    logic [9:0]  w_speed10;
    logic [2:0]  w_free;
    logic [2:0]  w_target;
    logic        w_spawn;
    logic [2:0]  w_raw;
    logic [2:0]  w_type_new;
    logic [7:0]  w_gap_reload;
    logic [9:0]  w_pos_nxt  [3];
    logic [2:0]  w_type_nxt [3];
    logic [2:0]  w_en_nxt;
    logic [7:0]  w_gap_nxt;

    // -------------------------------------------------------------------------
    // LFSR: free-running, independent of run; restart reseeds so the spawn
    // sequence after a restart replays the sequence seen after reset.
    // -------------------------------------------------------------------------
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (restart) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // -------------------------------------------------------------------------
    // Tick decode and spawn selection (all from start-of-cycle state)
    // -------------------------------------------------------------------------
    assign w_tick    = frame_tick & run & ~restart;
    assign w_speed10 = {6'd0, speed};
    assign w_free    = ~r_en;

    // Lowest-indexed free slot, one-hot; zero when all slots are busy.
    always_comb begin
        w_target = 3'b000;
        if (w_free[0]) begin
            w_target = 3'b001;
        end else if (w_free[1]) begin
            w_target = 3'b010;
        end else if (w_free[2]) begin
            w_target = 3'b100;
        end
    end

    // A zero gap with no free slot simply waits: the gap stays at zero and the
    // spawn fires on the first tick that finds a free slot.
    assign w_spawn = w_tick & (r_gap == 8'd0) & (|w_free);

    // raw 5..7 fold back onto the cactus types 2..4
    assign w_raw        = r_lfsr[2:0];
    assign w_type_new   = (w_raw > 3'd4) ? (w_raw - 3'd3) : w_raw;
    assign w_gap_reload = GAP_MIN + {2'b00, r_lfsr[5:0]};

    // -------------------------------------------------------------------------
    // Next-state for slots and gap counter
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_pos_nxt[i]  = r_pos[i];
            w_type_nxt[i] = r_type[i];
        end
        w_en_nxt  = r_en;
        w_gap_nxt = r_gap;

        if (restart) begin
            // Types deliberately hold across a restart.
            for (int i = 0; i < 3; i++) begin
                w_pos_nxt[i] = 10'd0;
            end
            w_en_nxt  = 3'b000;
            w_gap_nxt = GAP_MIN;
        end else if (w_tick) begin
            for (int i = 0; i < 3; i++) begin
                if (r_en[i]) begin
                    if (r_pos[i] <= w_speed10) begin
                        w_pos_nxt[i] = 10'd0;
                        w_en_nxt[i]  = 1'b0;
                    end else begin
                        w_pos_nxt[i] = r_pos[i] - w_speed10;
                    end
                end else if (w_spawn && w_target[i]) begin
                    // Only slots free at start of cycle can be targeted, so a
                    // slot retired on this tick is never respawned on it.
                    w_pos_nxt[i]  = SPAWN_POS;
                    w_type_nxt[i] = w_type_new;
                    w_en_nxt[i]   = 1'b1;
                end
            end

            if (w_spawn) begin
                w_gap_nxt = w_gap_reload;
            end else if (r_gap != 8'd0) begin
                w_gap_nxt = r_gap - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_pos[i]  <= 10'd0;
                r_type[i] <= 3'd0;
            end
            r_en          <= 3'b000;
            r_gap         <= GAP_MIN;
            r_spawn_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_pos[i]  <= w_pos_nxt[i];
                r_type[i] <= w_type_nxt[i];
            end
            r_en          <= w_en_nxt;
            r_gap         <= w_gap_nxt;
            r_spawn_pulse <= w_spawn;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs straight from registers
    // -------------------------------------------------------------------------
    assign new_danger_pos1 = r_pos[0];
    assign new_danger_pos2 = r_pos[1];
    assign new_danger_pos3 = r_pos[2];
    assign danger_type1    = r_type[0];
    assign danger_type2    = r_type[1];
    assign danger_type3    = r_type[2];
    assign danger_en1      = r_en[0];
    assign danger_en2      = r_en[1];
    assign danger_en3      = r_en[2];
    assign spawn_pulse     = r_spawn_pulse;

endmodule

// File: tb/tb_danger_scheduler.sv
// -----------------------------------------------------------------------------
// Directed bench for danger_scheduler. A small spec-level model tracks the
// LFSR (stepped every clock) and the slot/gap state (stepped per tick) so the
// bench can steer slots to chosen positions and predict spawn types.
// -----------------------------------------------------------------------------
module tb_danger_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic frame_tick;
    logic run;
    logic restart;
    logic [3:0] speed;
    logic [9:0] new_danger_pos1, new_danger_pos2, new_danger_pos3;
    logic [2:0] danger_type1, danger_type2, danger_type3;
    logic danger_en1, danger_en2, danger_en3;
    logic spawn_pulse;

    always #5 clk = ~clk;

    danger_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .run             (run),
        .restart         (restart),
        .speed           (speed),
        .new_danger_pos1 (new_danger_pos1),
        .new_danger_pos2 (new_danger_pos2),
        .new_danger_pos3 (new_danger_pos3),
        .danger_type1    (danger_type1),
        .danger_type2    (danger_type2),
        .danger_type3    (danger_type3),
        .danger_en1      (danger_en1),
        .danger_en2      (danger_en2),
        .danger_en3      (danger_en3),
        .spawn_pulse     (spawn_pulse)
    );

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int type_tbl [8] = '{0, 1, 2, 3, 4, 2, 3, 4};
    logic [15:0] m_lfsr;
    int   m_pos  [3];
    int   m_type [3];
    bit   m_en   [3];
    int   m_gap;
    bit   m_spawn;
    logic [15:0] m_last_lf;

    always @(posedge clk or posedge rst) begin
        if (rst)          m_lfsr <= 16'hACE1;
        else if (restart) m_lfsr <= 16'hACE1;
        else              m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pos[i] = 0; m_type[i] = 0; m_en[i] = 0;
        end
        m_gap = 40; m_spawn = 0; m_last_lf = 16'h0;
    endtask

    task automatic model_tick(input logic [3:0] spd, input logic rn);
        int tgt;
        bit sp;
        logic [15:0] lf;
        m_spawn = 0;
        if (!rn) return;
        lf  = m_lfsr;
        tgt = -1;
        for (int i = 2; i >= 0; i--) if (!m_en[i]) tgt = i;
        sp = (m_gap == 0) && (tgt >= 0);
        for (int i = 0; i < 3; i++) begin
            if (m_en[i]) begin
                if (m_pos[i] <= int'(spd)) begin
                    m_pos[i] = 0; m_en[i] = 0;
                end else begin
                    m_pos[i] = m_pos[i] - int'(spd);
                end
            end
        end
        if (sp) begin
            m_en[tgt] = 1; m_pos[tgt] = 700; m_type[tgt] = type_tbl[lf[2:0]];
            m_gap = 40 + int'(lf[5:0]);
            m_last_lf = lf;
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end
        m_spawn = sp;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".en1"},  32'(danger_en1), 32'(m_en[0]));
        check({tag, ".en2"},  32'(danger_en2), 32'(m_en[1]));
        check({tag, ".en3"},  32'(danger_en3), 32'(m_en[2]));
        check({tag, ".pos1"}, 32'(new_danger_pos1), m_pos[0]);
        check({tag, ".pos2"}, 32'(new_danger_pos2), m_pos[1]);
        check({tag, ".pos3"}, 32'(new_danger_pos3), m_pos[2]);
        check({tag, ".type1"}, 32'(danger_type1), m_type[0]);
        check({tag, ".type2"}, 32'(danger_type2), m_type[1]);
        check({tag, ".type3"}, 32'(danger_type3), m_type[2]);
        check({tag, ".spawn"}, 32'(spawn_pulse), 32'(m_spawn));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".en"},   32'({danger_en3, danger_en2, danger_en1}), 0);
        check({tag, ".pos1"}, 32'(new_danger_pos1), 0);
        check({tag, ".pos2"}, 32'(new_danger_pos2), 0);
        check({tag, ".pos3"}, 32'(new_danger_pos3), 0);
    endtask

    // ---------------- driver tasks ----------------
    // Drive a tick for one cycle, then return at the following falling edge,
    // where the registered result is visible.
    task automatic do_tick(input logic [3:0] spd, input logic rn);
        @(negedge clk);
        speed = spd; run = rn; frame_tick = 1'b1;
        model_tick(spd, rn);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_restart(input logic with_tick);
        @(negedge clk);
        restart = 1'b1; frame_tick = with_tick; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_pos[i] = 0; m_en[i] = 0;
        end
        m_gap = 40; m_spawn = 0;
        @(negedge clk);
        restart = 1'b0; frame_tick = 1'b0;
    endtask

    // Ticks 1..40 spawn nothing; tick 41 spawns into slot 1.
    task automatic first_spawn(input string tag);
        for (int k = 1; k <= 40; k++) begin
            do_tick(4'd4, 1'b1);
            check({tag, ".no_spawn_en"}, 32'({danger_en3, danger_en2, danger_en1}), 0);
        end
        do_tick(4'd4, 1'b1);
        check({tag, ".en1"},   32'(danger_en1), 1);
        check({tag, ".pos1"},  32'(new_danger_pos1), 700);
        check({tag, ".spawn"}, 32'(spawn_pulse), 1);
    endtask

    // ---------------- timeout ----------------
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    int first_type;
    int cnt;
    int gap_exp;
    logic [7:0] seen;
    logic [2:0] raw;

    initial begin
        rst = 1'b1; frame_tick = 1'b0; run = 1'b1; restart = 1'b0; speed = 4'd4;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset values
        check_cleared("reset");
        check("reset.type", 32'({danger_type3, danger_type2, danger_type1}), 0);
        check("reset.spawn", 32'(spawn_pulse), 0);

        // First spawn on tick 41, then scroll by 4
        @(negedge clk);
        rst = 1'b0;
        first_spawn("first");
        check("first.type1", 32'(danger_type1), type_tbl[m_last_lf[2:0]]);
        first_type = type_tbl[m_last_lf[2:0]];
        check_model("first");
        @(negedge clk);
        check("first.spawn_one_cycle", 32'(spawn_pulse), 0);
        do_tick(4'd4, 1'b1);
        check("first.pos1_next", 32'(new_danger_pos1), 696);

        // Freeze: ten ticks with run=0 change nothing
        for (int k = 0; k < 10; k++) do_tick(4'd4, 1'b0);
        check("freeze.pos1", 32'(new_danger_pos1), 696);
        check("freeze.en",   32'({danger_en3, danger_en2, danger_en1}), 3'b001);
        check("freeze.type1", 32'(danger_type1), first_type);
        check_model("freeze");

        // Retire boundary: 696 -> 21 -> 7, then pos 7 with speed 6 survives at 1
        repeat (45) do_tick(4'd15, 1'b1);
        do_tick(4'd14, 1'b1);
        check("b7.pos1", 32'(new_danger_pos1), 7);
        check("b7.en1",  32'(danger_en1), 1);
        do_tick(4'd6, 1'b1);
        check("b7s6.pos1", 32'(new_danger_pos1), 1);
        check("b7s6.en1",  32'(danger_en1), 1);
        check_model("b7s6");

        // Restart with a coincident tick: restart wins, types hold
        do_restart(1'b1);
        check_cleared("restart");
        check("restart.type1", 32'(danger_type1), first_type);
        check_model("restart");

        // Spawn timing and type replay after restart
        first_spawn("replay");
        check("replay.type1", 32'(danger_type1), first_type);

        // Retire boundary: 700 -> 10 -> 6, then pos 6 with speed 6 retires
        repeat (46) do_tick(4'd15, 1'b1);
        do_tick(4'd4, 1'b1);
        check("b6.pos1", 32'(new_danger_pos1), 6);
        check("b6.en1",  32'(danger_en1), 1);
        do_tick(4'd6, 1'b1);
        check("b6s6.pos1", 32'(new_danger_pos1), 0);
        check("b6s6.en1",  32'(danger_en1), 0);
        check_model("b6s6");

        // Full slots: build slot1 @700, slot2 @lowest, slot3 between
        do_restart(1'b0);
        cnt = 0;
        while (!m_en[0] && cnt < 200) begin do_tick(4'd0, 1'b1); cnt++; end
        do_tick(4'd15, 1'b1);
        cnt = 0;
        while (!m_en[1] && cnt < 200) begin do_tick(4'd0, 1'b1); cnt++; end
        cnt = 0;
        while (m_en[0] && cnt < 200) begin do_tick(4'd15, 1'b1); cnt++; end
        cnt = 0;
        while (!(m_en[0] && m_en[1] && m_en[2]) && cnt < 300) begin do_tick(4'd0, 1'b1); cnt++; end
        cnt = 0;
        while (m_gap != 0 && cnt < 200) begin do_tick(4'd0, 1'b1); cnt++; end
        for (int k = 0; k < 3; k++) begin
            do_tick(4'd0, 1'b1);
            check("full.no_spawn", 32'(spawn_pulse), 0);
            check("full.en", 32'({danger_en3, danger_en2, danger_en1}), 3'b111);
        end
        check_model("full");
        cnt = 0;
        while (m_pos[1] > 15 && cnt < 100) begin do_tick(4'd15, 1'b1); cnt++; end
        do_tick(4'(m_pos[1]), 1'b1);
        check("retireN.en", 32'({danger_en3, danger_en2, danger_en1}), 3'b101);
        check("retireN.pos2", 32'(new_danger_pos2), 0);
        check("retireN.spawn", 32'(spawn_pulse), 0);
        do_tick(4'd0, 1'b1);
        check("respawnN1.en", 32'({danger_en3, danger_en2, danger_en1}), 3'b111);
        check("respawnN1.pos2", 32'(new_danger_pos2), 700);
        check("respawnN1.spawn", 32'(spawn_pulse), 1);
        check("respawnN1.type2", 32'(danger_type2), type_tbl[m_last_lf[2:0]]);
        check_model("respawnN1");

        // Async reset between clock edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_cleared("async_rst");
        check("async_rst.type", 32'({danger_type3, danger_type2, danger_type1}), 0);
        check("async_rst.spawn", 32'(spawn_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        first_spawn("post_rst");
        check("post_rst.type1", 32'(danger_type1), first_type);

        // Type mapping and gap reload across many LFSR phases
        seen = 8'h00;
        for (int d = 0; d < 64 && seen != 8'hFF; d++) begin
            do_restart(1'b0);
            repeat (40) do_tick(4'd4, 1'b1);
            repeat (d) @(negedge clk);
            do_tick(4'd4, 1'b1);
            raw = m_last_lf[2:0];
            seen[raw] = 1'b1;
            check("map.en1", 32'(danger_en1), 1);
            check("map.type1", 32'(danger_type1), type_tbl[raw]);
            gap_exp = 40 + int'(m_last_lf[5:0]);
            repeat (gap_exp) do_tick(4'd0, 1'b1);
            check("gap.not_yet", 32'(danger_en2), 0);
            do_tick(4'd0, 1'b1);
            check("gap.spawn_en2", 32'(danger_en2), 1);
            check("gap.spawn_pulse", 32'(spawn_pulse), 1);
        end
        check("map.all_raw_values", 32'(seen), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/danger_scheduler.md
# danger_scheduler

Obstacle scheduler that sits directly upstream of the danger renderer. It owns three obstacle slots and, once per video frame, scrolls each active slot left by the current game speed. It retires slots that leave the screen and spawns new obstacles of pseudo-random type after a pseudo-random frame gap. Its registered outputs drive the renderer's per-slot position, type and enable inputs unchanged.

## Interface
- SPAWN_X, 700: right-edge x position given to a newly spawned obstacle (off-screen right of the 640-pixel area).
- MIN_GAP, 40: minimum number of frame ticks between spawns.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset and on restart; must be non-zero.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking
- run  in  1  1 = game running; 0 = freeze all state except LFSR
- restart  in  1  one-cycle synchronous pulse: clear all slots and reload the gap counter
- speed  in  4  pixels moved per frame tick; 0 = no motion
- new_danger_pos1/2/3  out  10  right-edge x of slot n
- danger_type1/2/3  out  3  0 low bird, 1 high bird, 2 small cactus, 3 many cactus, 4 big cactus
- danger_en1/2/3  out  1  slot n active
- spawn_pulse  out  1  one-cycle pulse in the cycle after a spawn

## Operation
- **Reset values (rst=1, async):** all pos = 0, all type = 0, all en = 0, spawn_pulse = 0, gap counter = MIN_GAP, LFSR = LFSR_SEED.
- **LFSR:** 16-bit Fibonacci, shifts left every clk regardless of run. Feedback = l[15]^l[13]^l[12]^l[10], entering at bit 0.
- **Type mapping:** raw = lfsr[2:0]. raw 0..4 is used as-is; 5→2, 6→3, 7→4 (type = raw−3).
- **Gap reload value:** MIN_GAP + lfsr[5:0], held in an 8-bit counter.
- **Restart:** has priority over frame_tick. It sets all en = 0, all pos = 0, gap = MIN_GAP and LFSR = LFSR_SEED. Types hold their values.
- **Tick processing:** on a clk where frame_tick=1, run=1 and restart=0, all of the following evaluate from start-of-cycle state and commit together:
  - **Move:** for each slot with en=1:
    - if pos ≤ speed → pos = 0, en = 0 (retire);
    - else pos = pos − speed.
    - Slots with en=0 are not moved.
  - **Gap:** if gap > 0, gap decrements by 1.
  - **Spawn:** occurs if gap == 0 at start of cycle and at least one slot had en=0 at start of cycle.
    - The target is the lowest-indexed slot that was free at start of cycle.
    - The target gets en = 1, pos = SPAWN_X, type = mapped LFSR value.
    - gap reloads to MIN_GAP + lfsr[5:0], using the same LFSR sample as the type.
  - **Pending spawn:** if gap == 0 and no slot is free, gap holds at 0 and the spawn fires on the first tick that finds a free slot.
  - **Same-tick retire:** a slot retired on a tick is not respawned on that same tick.
- **run = 0:** ticks are ignored; pos, en, type and gap hold.
- **Outputs:** always driven directly from the slot registers; no combinational path from inputs.
- **Arithmetic:** comparison and subtraction are 10-bit unsigned, with speed zero-extended. Pos never underflows.

## Timing
- All outputs change only on the clk edge that samples frame_tick; they are valid the next cycle.
- **Latency:** frame_tick to updated pos/en/type = 1 cycle. spawn_pulse is high for exactly that one cycle.
- frame_tick is asserted in blanking, so outputs are stable before the renderer latches positions at v_cnt 308.
- Back-to-back frame_tick pulses on consecutive cycles are each processed fully.
- **Reset mid-operation:** all state returns to reset values immediately, independent of clk.

## Test plan
- **Reset and first spawn:** release rst with run=1, speed=4, issue ticks → en all 0 through tick 40; tick 41 → en1=1, pos1=700, spawn_pulse high 1 cycle; tick 42 → pos1=696.
- **Retire boundary:** slot pos=6 with speed=6 → next tick pos=0, en=0; pos=7 → pos=1, en stays 1.
- **Type mapping:** force lfsr[2:0] = 0..7 across spawns → types 0,1,2,3,4,2,3,4 respectively; gap reload = 40 + lfsr[5:0].
- **Full slots:** three slots active, gap reaches 0 → gap holds 0, no spawn. When slot2 retires on tick N: no spawn on N; spawn into slot2 on N+1 at pos 700.
- **Freeze and restart:** run=0 with 10 ticks → all outputs unchanged. restart with frame_tick in the same cycle → all en=0, pos=0, and the first spawn again occurs on tick 41 with the same type sequence as after reset.
- **Async reset mid-frame:** assert rst between clk edges with slots active → outputs reach reset values before the next edge.
